// File: rtl/game_pkg.sv
// Shared mode/state encodings and the difficulty (clk_div limit) table
// for the game session sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE      = 3'd0,
    MODE_COUNTDOWN = 3'd1,
    MODE_PLAY      = 3'd2,
    MODE_PAUSE     = 3'd3,
    MODE_END       = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    COUNT = 3'd2,
    PLAY  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam logic [22:0] DIFF_TBL [0:3] = '{
    23'd4_999_999, 23'd3_749_999, 23'd2_499_999, 23'd1_249_999
  };

  // LOAD still reports idle so main_game does not start scrolling early.
  function automatic mode_e mode_of(input state_e s);
    case (s)
      COUNT:   mode_of = MODE_COUNTDOWN;
      PLAY:    mode_of = MODE_PLAY;
      PAUSE:   mode_of = MODE_PAUSE;
      DONE:    mode_of = MODE_END;
      default: mode_of = MODE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/game_sequencer_btn_edge.sv
// Button conditioner: 2-FF synchroniser, rising-edge detect, and a
// registered one-cycle press pulse (3 cycles from button to pulse).
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic press_q, press_d;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_sequencer.sv
// Play-session controller around main_game: start, countdown, play, pause and
// end-of-game flow, with per-segment note fetch from the synchronous song ROM.
module game_sequencer
  import game_pkg::*;
#(
  parameter int         ADDR_W      = 6,
  parameter int         SONG_LEN    = 16,
  parameter int         SEG_BEATS   = 32,
  parameter int         COUNT_BEATS = 4,
  parameter logic [7:0] MISS_LIMIT  = 8'h25
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  input  logic              pause_btn,
  input  logic [1:0]        diff_sel,
  input  logic              beat_clk,
  input  logic [7:0]        num_misses,
  input  logic [31:0]       rom_data1,
  input  logic [31:0]       rom_data2,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       notes1,
  output logic [31:0]       notes2,
  output logic [2:0]        mode,
  output logic [22:0]       diff,
  output logic              game_over,
  output logic              win
);

  localparam int BEAT_W = (SEG_BEATS > 1) ? $clog2(SEG_BEATS) : 1;
  localparam int CNT_W  = (COUNT_BEATS > 1) ? $clog2(COUNT_BEATS) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SEG_BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(COUNT_BEATS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  logic start_p, pause_p, loss, seg_end;

  state_e             state_q, state_d;
  state_e             resume_q, resume_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [31:0]        notes1_q, notes1_d;
  logic [31:0]        notes2_q, notes2_d;
  logic               fetch_q, fetch_d;
  logic [22:0]        diff_q, diff_d;
  logic               win_q, win_d;
  logic               game_over_q, game_over_d;

  btn_edge u_start_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_in (start_btn),
    .press  (start_p)
  );

  btn_edge u_pause_edge (
    .clk    (clk),
    .rst    (rst),
    .btn_in (pause_btn),
    .press  (pause_p)
  );

  // BCD digits order the same way as binary, so a plain compare works.
  assign loss    = (num_misses >= MISS_LIMIT);
  assign seg_end = beat_clk && (beat_cnt_q == BEAT_LAST);

  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    cnt_d      = cnt_q;
    beat_cnt_d = beat_cnt_q;
    rom_addr_d = rom_addr_q;
    notes1_d   = notes1_q;
    notes2_d   = notes2_q;
    fetch_d    = 1'b0;
    diff_d     = diff_q;
    win_d      = win_q;

    // A fetch issued last cycle lands regardless of what the FSM does now.
    if (fetch_q) begin
      notes1_d = rom_data1;
      notes2_d = rom_data2;
    end

    case (state_q)
      IDLE: begin
        if (start_p) begin
          diff_d     = DIFF_TBL[diff_sel];
          rom_addr_d = '0;
          cnt_d      = '0;
          beat_cnt_d = '0;
          win_d      = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        notes1_d = rom_data1;
        notes2_d = rom_data2;
        state_d  = COUNT;
      end
      COUNT: begin
        if (loss) begin
          win_d   = 1'b0;
          state_d = DONE;
        end else if (pause_p) begin
          resume_d = COUNT;
          state_d  = PAUSE;
        end else if (beat_clk) begin
          if (cnt_q == CNT_LAST) begin
            beat_cnt_d = '0;
            state_d    = PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PLAY: begin
        if (loss) begin
          win_d   = 1'b0;
          state_d = DONE;
        end else if (seg_end) begin
          if (rom_addr_q == ADDR_LAST) begin
            win_d   = 1'b1;
            state_d = DONE;
          end else begin
            beat_cnt_d = '0;
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            fetch_d    = 1'b1;
          end
        end else if (pause_p) begin
          resume_d = PLAY;
          state_d  = PAUSE;
        end else if (beat_clk) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
      end
      PAUSE: begin
        if (loss) begin
          win_d   = 1'b0;
          state_d = DONE;
        end else if (pause_p) begin
          state_d = resume_q;
        end
      end
      DONE: begin
        if (start_p) begin
          win_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mode_d      = mode_of(state_d);
    game_over_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      resume_q    <= IDLE;
      mode_q      <= MODE_IDLE;
      cnt_q       <= '0;
      beat_cnt_q  <= '0;
      rom_addr_q  <= '0;
      notes1_q    <= '0;
      notes2_q    <= '0;
      fetch_q     <= 1'b0;
      diff_q      <= DIFF_TBL[0];
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      rom_addr_q  <= rom_addr_d;
      notes1_q    <= notes1_d;
      notes2_q    <= notes2_d;
      fetch_q     <= fetch_d;
      diff_q      <= diff_d;
      win_q       <= win_d;
      game_over_q <= game_over_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign notes1    = notes1_q;
  assign notes2    = notes2_q;
  assign mode      = mode_q;
  assign diff      = diff_q;
  assign game_over = game_over_q;
  assign win       = win_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized self-checking bench for game_sequencer against a beat-count
// reference model of the session (countdown, segments, pause, win/loss).
module tb_game_sequencer;

  localparam int ADDR_W      = 6;
  localparam int SONG_LEN    = 4;
  localparam int SEG_BEATS   = 32;
  localparam int COUNT_BEATS = 4;
  localparam logic [22:0] EXP_DIFF [0:3] = '{
    23'd4_999_999, 23'd3_749_999, 23'd2_499_999, 23'd1_249_999
  };

  logic              clk = 1'b0;
  logic              rst;
  logic              start_btn, pause_btn, beat_clk;
  logic [1:0]        diff_sel;
  logic [7:0]        num_misses;
  logic [31:0]       rom_data1, rom_data2;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       notes1, notes2;
  logic [2:0]        mode;
  logic [22:0]       diff;
  logic              game_over, win;

  logic [31:0] rom1 [0:63];
  logic [31:0] rom2 [0:63];

  int checks = 0;
  int failures = 0;

  // model: m_state uses the mode numbering (0 idle,1 count,2 play,3 pause,4 end)
  int m_state, m_resume, m_count, m_played;
  bit m_win;

  game_sequencer #(
    .ADDR_W      (ADDR_W),
    .SONG_LEN    (SONG_LEN),
    .SEG_BEATS   (SEG_BEATS),
    .COUNT_BEATS (COUNT_BEATS),
    .MISS_LIMIT  (8'h25)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .diff_sel   (diff_sel),
    .beat_clk   (beat_clk),
    .num_misses (num_misses),
    .rom_data1  (rom_data1),
    .rom_data2  (rom_data2),
    .rom_addr   (rom_addr),
    .notes1     (notes1),
    .notes2     (notes2),
    .mode       (mode),
    .diff       (diff),
    .game_over  (game_over),
    .win        (win)
  );

  always #50 clk = ~clk;

  // Synchronous ROM clocked on the falling edge: data for the current address
  // is ready before the next rising edge.
  always @(negedge clk) begin
    rom_data1 <= rom1[rom_addr];
    rom_data2 <= rom2[rom_addr];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int exp_addr();
    if (m_played >= SONG_LEN * SEG_BEATS) return SONG_LEN - 1;
    return m_played / SEG_BEATS;
  endfunction

  // Button press (optionally with a beat strobe on the cycle the press pulse is seen).
  task automatic press(input bit s, input bit p, input bit with_beat);
    start_btn = s;
    pause_btn = p;
    tick(3);
    if (with_beat) beat_clk = 1'b1;
    tick(1);
    beat_clk  = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    if (s && m_state == 0) begin
      m_state = 1; m_count = 0; m_played = 0; m_win = 0;
    end else if (s && m_state == 4) begin
      m_state = 0; m_win = 0;
    end else if (p && (m_state == 1 || m_state == 2)) begin
      m_resume = m_state; m_state = 3;
    end else if (p && m_state == 3) begin
      m_state = m_resume;
    end
    tick(3);
  endtask

  task automatic do_beat();
    int a0, a1;
    a0 = exp_addr();
    beat_clk = 1'b1;
    tick(1);
    beat_clk = 1'b0;
    if (m_state == 1) begin
      m_count++;
      if (m_count == COUNT_BEATS) begin m_state = 2; m_played = 0; end
    end else if (m_state == 2) begin
      m_played++;
      if (m_played == SONG_LEN * SEG_BEATS) begin m_state = 4; m_win = 1; end
    end
    a1 = exp_addr();
    checks++;
    if (mode !== 3'(m_state)) begin
      failures++; $display("FAIL beat_mode: got %0d want %0d", mode, m_state);
    end
    checks++;
    if (rom_addr !== ADDR_W'(a1)) begin
      failures++; $display("FAIL beat_addr: got %0d want %0d", rom_addr, a1);
    end
    checks++;
    if (game_over !== (m_state == 4) || (m_state == 4 && win !== m_win)) begin
      failures++; $display("FAIL beat_end: game_over=%0b win=%0b want state %0d win %0b", game_over, win, m_state, m_win);
    end
    checks++;
    if (notes1 !== rom1[a0] || notes2 !== rom2[a0]) begin
      failures++; $display("FAIL notes_early: got %h/%h want %h/%h", notes1, notes2, rom1[a0], rom2[a0]);
    end
    tick(1);
    checks++;
    if (notes1 !== rom1[a1] || notes2 !== rom2[a1]) begin
      failures++; $display("FAIL notes_latch: got %h/%h want %h/%h", notes1, notes2, rom1[a1], rom2[a1]);
    end
    tick($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if (rom_addr !== '0 || notes1 !== '0 || notes2 !== '0 || mode !== 3'd0 ||
        game_over !== 1'b0 || win !== 1'b0) begin
      failures++; $display("FAIL reset_outs: addr=%0d n1=%h n2=%h mode=%0d go=%0b win=%0b want all 0",
                           rom_addr, notes1, notes2, mode, game_over, win);
    end
    checks++;
    if (diff !== EXP_DIFF[0]) begin
      failures++; $display("FAIL reset_diff: got %0d want %0d", diff, EXP_DIFF[0]);
    end
    rst = 1'b0;
    m_state = 0; m_win = 0; m_played = 0; m_count = 0;
    tick(2);
    // pause is ignored in IDLE
    press(0, 1, 0);
    checks++;
    if (mode !== 3'd0) begin
      failures++; $display("FAIL idle_pause: mode=%0d want 0", mode);
    end
  endtask

  task automatic test_start();
    diff_sel  = 2'd2;
    start_btn = 1'b1;
    tick(3);
    checks++;
    if (mode !== 3'd0 || diff !== EXP_DIFF[0]) begin
      failures++; $display("FAIL start_early: mode=%0d diff=%0d want 0/%0d", mode, diff, EXP_DIFF[0]);
    end
    tick(1);
    checks++;
    if (diff !== 23'd2_499_999 || rom_addr !== '0 || mode !== 3'd0) begin
      failures++; $display("FAIL start_load: diff=%0d addr=%0d mode=%0d want 2499999/0/0", diff, rom_addr, mode);
    end
    tick(1);
    checks++;
    if (notes1 !== rom1[0] || notes2 !== rom2[0] || mode !== 3'd1) begin
      failures++; $display("FAIL start_notes: n1=%h n2=%h mode=%0d want %h/%h/1", notes1, notes2, mode, rom1[0], rom2[0]);
    end
    start_btn = 1'b0;
    m_state = 1; m_count = 0; m_played = 0; m_win = 0;
    tick(3);
  endtask

  task automatic test_countdown();
    for (int i = 0; i < COUNT_BEATS; i++) do_beat();
    checks++;
    if (mode !== 3'd2) begin
      failures++; $display("FAIL count_play: mode=%0d want 2", mode);
    end
    for (int i = 0; i < SEG_BEATS; i++) do_beat();
    checks++;
    if (rom_addr !== ADDR_W'(1)) begin
      failures++; $display("FAIL first_seg: addr=%0d want 1", rom_addr);
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 10; i++) do_beat();
    press(0, 1, 1);  // pause coincides with a beat: that beat is dropped
    checks++;
    if (mode !== 3'd3) begin
      failures++; $display("FAIL pause_enter: mode=%0d want 3", mode);
    end
    for (int i = 0; i < 5; i++) do_beat();
    press(0, 1, 0);
    checks++;
    if (mode !== 3'd2 || rom_addr !== ADDR_W'(1)) begin
      failures++; $display("FAIL pause_resume: mode=%0d addr=%0d want 2/1", mode, rom_addr);
    end
    for (int i = 0; i < 21; i++) do_beat();
    checks++;
    if (rom_addr !== ADDR_W'(1)) begin
      failures++; $display("FAIL pause_21: addr=%0d want 1", rom_addr);
    end
    do_beat();
    checks++;
    if (rom_addr !== ADDR_W'(2)) begin
      failures++; $display("FAIL pause_22: addr=%0d want 2", rom_addr);
    end
  endtask

  task automatic test_reset_mid_play();
    for (int i = 0; i < SEG_BEATS - 1; i++) do_beat();
    beat_clk = 1'b1;
    tick(1);
    beat_clk = 1'b0;
    checks++;
    if (rom_addr !== ADDR_W'(3)) begin
      failures++; $display("FAIL pre_reset_addr: addr=%0d want 3", rom_addr);
    end
    rst = 1'b1;  // lands while the segment-3 fetch is pending
    #1;
    checks++;
    if (rom_addr !== '0 || notes1 !== '0 || notes2 !== '0 || mode !== 3'd0 ||
        game_over !== 1'b0 || win !== 1'b0 || diff !== EXP_DIFF[0]) begin
      failures++; $display("FAIL async_reset: addr=%0d n1=%h mode=%0d diff=%0d go=%0b win=%0b",
                           rom_addr, notes1, mode, diff, game_over, win);
    end
    tick(2);
    rst = 1'b0;
    m_state = 0; m_played = 0; m_count = 0; m_win = 0;
    tick(3);
    checks++;
    if (notes1 !== '0 || notes2 !== '0 || mode !== 3'd0 || rom_addr !== '0) begin
      failures++; $display("FAIL reset_abort: n1=%h n2=%h mode=%0d addr=%0d want 0", notes1, notes2, mode, rom_addr);
    end
  endtask

  task automatic test_random_win();
    int sel;
    bit wb;
    sel = $urandom_range(0, 3);
    diff_sel = 2'(sel);
    press(1, 0, 0);
    checks++;
    if (diff !== EXP_DIFF[sel] || mode !== 3'd1) begin
      failures++; $display("FAIL rand_start: diff=%0d mode=%0d want %0d/1", diff, mode, EXP_DIFF[sel]);
    end
    for (int i = 0; i < 2000 && m_state != 4; i++) begin
      if ($urandom_range(0, 15) == 0 &&
          !(m_state == 2 && (m_played % SEG_BEATS) == SEG_BEATS - 1)) begin
        wb = 1'($urandom_range(0, 1));
        press(0, 1, wb);
        checks++;
        if (mode !== 3'd3) begin
          failures++; $display("FAIL rand_pause: mode=%0d want 3", mode);
        end
        repeat ($urandom_range(0, 2)) do_beat();
        press(0, 1, 0);
        checks++;
        if (mode !== 3'(m_state)) begin
          failures++; $display("FAIL rand_resume: mode=%0d want %0d", mode, m_state);
        end
      end else begin
        do_beat();
      end
    end
    tick(5);
    checks++;
    if (game_over !== 1'b1 || win !== 1'b1 || mode !== 3'd4) begin
      failures++; $display("FAIL win_hold: go=%0b win=%0b mode=%0d want 1/1/4", game_over, win, mode);
    end
    press(1, 0, 0);
    checks++;
    if (game_over !== 1'b0 || win !== 1'b0 || mode !== 3'd0) begin
      failures++; $display("FAIL restart: go=%0b win=%0b mode=%0d want 0/0/0", game_over, win, mode);
    end
  endtask

  task automatic test_loss_in_pause();
    diff_sel = 2'($urandom_range(0, 3));
    press(1, 1, 0);  // simultaneous start+pause in IDLE is start only
    checks++;
    if (mode !== 3'd1) begin
      failures++; $display("FAIL start_and_pause: mode=%0d want 1", mode);
    end
    for (int i = 0; i < COUNT_BEATS + 3; i++) do_beat();
    press(0, 1, 0);
    num_misses = 8'h24;
    tick(3);
    checks++;
    if (mode !== 3'd3 || game_over !== 1'b0) begin
      failures++; $display("FAIL below_limit: mode=%0d go=%0b want 3/0", mode, game_over);
    end
    num_misses = 8'h25;
    tick(1);
    m_state = 4; m_win = 0;
    checks++;
    if (game_over !== 1'b1 || win !== 1'b0 || mode !== 3'd4) begin
      failures++; $display("FAIL pause_loss: go=%0b win=%0b mode=%0d want 1/0/4", game_over, win, mode);
    end
    num_misses = 8'h00;
    press(1, 0, 0);
  endtask

  task automatic test_loss_vs_segend();
    press(1, 0, 0);
    for (int i = 0; i < COUNT_BEATS + SEG_BEATS - 1; i++) do_beat();
    beat_clk   = 1'b1;
    num_misses = 8'h25;
    tick(1);
    beat_clk = 1'b0;
    m_state = 4; m_win = 0;
    checks++;
    if (game_over !== 1'b1 || win !== 1'b0 || mode !== 3'd4 || rom_addr !== '0) begin
      failures++; $display("FAIL loss_priority: go=%0b win=%0b mode=%0d addr=%0d want 1/0/4/0",
                           game_over, win, mode, rom_addr);
    end
    num_misses = 8'h00;
    press(1, 0, 0);
    checks++;
    if (mode !== 3'd0 || game_over !== 1'b0) begin
      failures++; $display("FAIL loss_restart: mode=%0d go=%0b want 0/0", mode, game_over);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom1[i] = $urandom();
      rom2[i] = $urandom();
    end
    rst        = 1'b0;
    start_btn  = 1'b0;
    pause_btn  = 1'b0;
    beat_clk   = 1'b0;
    diff_sel   = 2'd0;
    num_misses = 8'h00;
    m_resume   = 0;
    #2;
    test_reset();
    test_start();
    test_countdown();
    test_pause();
    test_reset_mid_play();
    test_random_win();
    test_loss_in_pause();
    test_loss_vs_segend();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
